// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two clocked writes (port 1 wins),
// optional zero register and per-register busy scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    clrn,
   input  logic [NRD*ADDR_W-1:0]   ra,
   output logic [NRD*DATA_W-1:0]   rd,
   output logic [NRD-1:0]          rbusy,
   input  logic                    we0,
   input  logic [ADDR_W-1:0]       wn0,
   input  logic [DATA_W-1:0]       d0,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       wn1,
   input  logic [DATA_W-1:0]       d1,
   input  logic                    bset,
   input  logic [ADDR_W-1:0]       bsn,
   output logic [ADDR_W:0]         nbusy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nx;
   logic [DEPTH-1:0]  wr0_hit;
   logic [DEPTH-1:0]  wr1_hit;
   logic [DEPTH-1:0]  bs_hit;
   logic [ADDR_W:0]   cnt_nx;

   // Per-register decode; the zero register never accepts a write or a reservation.
   always_comb begin
      wr0_hit = '0;
      wr1_hit = '0;
      bs_hit  = '0;
      busy_nx = '0;
      cnt_nx  = '0;
      for (int r = 0; r < DEPTH; r++) begin
         if (!(ZERO_REG != 0 && r == 0)) begin
            wr0_hit[r] = we0  && (wn0 == ADDR_W'(r));
            wr1_hit[r] = we1  && (wn1 == ADDR_W'(r));
            bs_hit[r]  = bset && (bsn == ADDR_W'(r));
         end
         busy_nx[r] = bs_hit[r] | (busy[r] & ~(wr0_hit[r] | wr1_hit[r]));
         cnt_nx     = cnt_nx + {{ADDR_W{1'b0}}, busy_nx[r]};
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
         busy  <= '0;
         nbusy <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (wr1_hit[r])      regs[r] <= d1;
            else if (wr0_hit[r]) regs[r] <= d0;
         end
         busy  <= busy_nx;
         nbusy <= cnt_nx;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign a = ra[k*ADDR_W +: ADDR_W];

      always_comb begin
         data = regs[a];
         bsy  = busy[a];
`ifdef REGFILE_BYPASS_EN
         if (wr1_hit[a])      data = d1;
         else if (wr0_hit[a]) data = d0;
         // A write retires the pending load unless a new reservation lands on it.
         if ((wr0_hit[a] | wr1_hit[a]) & ~bs_hit[a]) bsy = 1'b0;
`endif
         if (ZERO_REG != 0 && a == '0) begin
            data = '0;
            bsy  = 1'b0;
         end
      end

      assign rd[k*DATA_W +: DATA_W] = data;
      assign rbusy[k]               = bsy;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (NRD=4, ZERO_REG=1); expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 4;

   logic              clk;
   logic              clrn;
   logic [NRD*AW-1:0] ra;
   logic [NRD*DW-1:0] rd;
   logic [NRD-1:0]    rbusy;
   logic              we0, we1, bset;
   logic [AW-1:0]     wn0, wn1, bsn;
   logic [DW-1:0]     d0, d1;
   logic [AW:0]       nbusy;

   logic [31:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1)) dut (
      .clk(clk), .clrn(clrn), .ra(ra), .rd(rd), .rbusy(rbusy),
      .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
      .bset(bset), .bsn(bsn), .nbusy(nbusy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; bset = 0;
   endtask

   task automatic set_ra(input int k, input logic [AW-1:0] a);
      ra[k*AW +: AW] = a;
   endtask

   task automatic push(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=<empty queue>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, e);
         end
      end
   endtask

   function automatic logic [31:0] rdp(input int k);
      return rd[k*DW +: DW];
   endfunction

   function automatic logic [31:0] nb();
      return {{(31-AW){1'b0}}, nbusy};
   endfunction

   function automatic logic [31:0] rb(input int k);
      return {31'b0, rbusy[k]};
   endfunction

   initial begin
      logic [AW-1:0] a;
      logic [31:0]   v;

      clrn = 0; ra = '0; idle(); wn0 = '0; wn1 = '0; bsn = '0; d0 = '0; d1 = '0;
      set_ra(0, 5);
      #2;
      push(32'h0); check("reset_rd", rdp(0));
      push(32'h0); check("reset_nbusy", nb());
      push(32'h0); check("reset_rbusy", rb(0));
      #10 clrn = 1;
      tick();

      // Reset pulse mid-cycle clears array and busy state immediately
      we0 = 1; wn0 = 5; d0 = 32'hDEADBEEF; bset = 1; bsn = 6;
      tick(); idle(); set_ra(1, 6);
      push(32'hDEADBEEF); check("pre_reset_rd", rdp(0));
      push(32'd1);        check("pre_reset_nbusy", nb());
      #3 clrn = 0;
      #1;
      push(32'h0); check("async_reset_rd", rdp(0));
      push(32'h0); check("async_reset_nbusy", nb());
      push(32'h0); check("async_reset_rbusy", rb(1));
      #1 clrn = 1;
      tick();

      // Zero register ignores writes and reservations
      set_ra(0, 0);
      we0 = 1; wn0 = 0; d0 = 32'h1234; bset = 1; bsn = 0;
      #1;
      push(32'h0); check("zero_rd_same_cycle", rdp(0));
      tick(); idle();
      push(32'h0); check("zero_rd", rdp(0));
      push(32'h0); check("zero_rbusy", rb(0));
      push(32'h0); check("zero_nbusy", nb());

      // Write collision: port 1 wins
      set_ra(0, 7);
      we0 = 1; wn0 = 7; d0 = 32'hA; we1 = 1; wn1 = 7; d1 = 32'hB;
      #1;
      push(BYP ? 32'hB : 32'h0); check("collide_same_cycle", rdp(0));
      tick(); idle();
      push(32'hB); check("collide_rd", rdp(0));

      // Busy scoreboard
      set_ra(1, 9);
      bset = 1; bsn = 9;
      tick(); idle();
      push(32'd1); check("bset_rbusy", rb(1));
      push(32'd1); check("bset_nbusy", nb());
      we1 = 1; wn1 = 9; d1 = 32'h55;
      #1;
      push(BYP ? 32'd0 : 32'd1); check("clear_rbusy_same_cycle", rb(1));
      push(BYP ? 32'h55 : 32'h0); check("clear_rd_same_cycle", rdp(1));
      tick(); idle();
      push(32'd0);  check("clear_rbusy", rb(1));
      push(32'd0);  check("clear_nbusy", nb());
      push(32'h55); check("clear_rd", rdp(1));
      bset = 1; bsn = 9; we0 = 1; wn0 = 9; d0 = 32'h66;
      #1;
      push(32'd0); check("bset_wr_rbusy_same_cycle", rb(1));
      tick(); idle();
      push(32'd1);  check("bset_wr_rbusy", rb(1));
      push(32'd1);  check("bset_wr_nbusy", nb());
      push(32'h66); check("bset_wr_rd", rdp(1));
      bset = 1; bsn = 10;
      tick(); idle();
      push(32'd2); check("two_busy_nbusy", nb());

      // Multi-port preload r1..r4 and read on all four ports
      we0 = 1; wn0 = 1; d0 = 32'h11; we1 = 1; wn1 = 2; d1 = 32'h22;
      tick();
      wn0 = 3; d0 = 32'h33; wn1 = 4; d1 = 32'h44;
      tick(); idle();
      for (int k = 0; k < NRD; k++) set_ra(k, AW'(k + 1));
      #1;
      for (int k = 0; k < NRD; k++) begin
         push(32'h11 * (k + 1));
         check($sformatf("multiport_rd%0d", k), rdp(k));
      end

      // Bypass: same-cycle read of a register being written
      set_ra(0, 3); set_ra(2, 4);
      we0 = 1; wn0 = 3; d0 = 32'h77; we1 = 1; wn1 = 4; d1 = 32'h88;
      #1;
      push(BYP ? 32'h77 : 32'h33); check("bypass_p0", rdp(0));
      push(BYP ? 32'h88 : 32'h44); check("bypass_p1", rdp(2));
      tick(); idle();
      push(32'h77); check("after_bypass_p0", rdp(0));
      push(32'h88); check("after_bypass_p1", rdp(2));

      // Random write/read-back through port 0 and port 3
      for (int i = 0; i < 12; i++) begin
         a = AW'($urandom_range(1, 31));
         v = $urandom;
         we0 = 1; wn0 = a; d0 = v;
         tick(); idle();
         set_ra(3, a);
         #1;
         push(v); check($sformatf("rand_rd_r%0d", a), rdp(3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
